// File: rtl/ip2_dnn_responder.sv
// rtl/ip2_dnn_responder.sv - IP2 DNN output emulator: answers each trigger rise with two serial streams
module ip2_dnn_responder #(
  parameter int   WIDTH      = 48,
  parameter int   LAT_W      = 6,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             dut_i_reset_not,
  input  logic             dut_i_vin_test_trig_out,
  input  logic [WIDTH-1:0] cfg_pattern_0,
  input  logic [WIDTH-1:0] cfg_pattern_1,
  input  logic [LAT_W-1:0] cfg_latency,
  output logic             dut_o_dnn_output_0,
  output logic             dut_o_dnn_output_1,
  output logic             status_busy,
  output logic             status_done,
  output logic [7:0]       status_overrun_cnt,
  output logic [2:0]       responder_state
);

  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RESET_HOLD = 3'd1,
    ST_ARMED      = 3'd2,
    ST_LATENCY    = 3'd3,
    ST_SHIFT      = 3'd4,
    ST_DONE       = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic               trig_q, trig_d;
  logic [WIDTH-1:0]   sh0_q, sh0_d;
  logic [WIDTH-1:0]   sh1_q, sh1_d;
  logic [LAT_W-1:0]   cnt_q, cnt_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic               out0_q, out0_d;
  logic               out1_q, out1_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [7:0]         ovr_q, ovr_d;
  logic               rise;
  logic               abort;

  always_comb begin
    state_d = state_q;
    trig_d  = dut_i_vin_test_trig_out;
    sh0_d   = sh0_q;
    sh1_d   = sh1_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    ovr_d   = ovr_q;
    rise    = dut_i_vin_test_trig_out & ~trig_q;
    abort   = ~dut_i_reset_not && (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE:       state_d = dut_i_reset_not ? ST_ARMED : ST_RESET_HOLD;
      ST_RESET_HOLD: if (dut_i_reset_not) state_d = ST_ARMED;
      ST_ARMED: begin
        if (rise) begin
          sh0_d = cfg_pattern_0;
          sh1_d = cfg_pattern_1;
          bit_d = '0;
          if (cfg_latency == '0) begin
            state_d = ST_SHIFT;
          end else begin
            cnt_d   = cfg_latency;
            state_d = ST_LATENCY;
          end
        end
      end
      ST_LATENCY: begin
        cnt_d = cnt_q - LAT_W'(1);
        if (cnt_q <= LAT_W'(1)) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        sh0_d = sh0_q << 1;
        sh1_d = sh1_q << 1;
        bit_d = bit_q + BIT_W'(1);
        if (bit_q == BIT_W'(WIDTH - 1)) begin
          bit_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE:       state_d = ST_ARMED;
      default:       state_d = ST_IDLE;
    endcase

    // Triggers that land while a response is in flight are only counted, never queued
    if (rise && !abort && (state_q == ST_LATENCY || state_q == ST_SHIFT) && ovr_q != 8'hFF)
      ovr_d = ovr_q + 8'd1;

    // reset_not low beats everything, including a capture in the same cycle
    if (abort) begin
      state_d = ST_RESET_HOLD;
      sh0_d   = '0;
      sh1_d   = '0;
      cnt_d   = '0;
      bit_d   = '0;
    end

    out0_d = (state_q == ST_SHIFT && !abort) ? sh0_q[WIDTH-1] : IDLE_LEVEL;
    out1_d = (state_q == ST_SHIFT && !abort) ? sh1_q[WIDTH-1] : IDLE_LEVEL;
    done_d = (state_q == ST_DONE) && !abort;
    busy_d = (state_d == ST_LATENCY) || (state_d == ST_SHIFT);

    if (!enable) begin
      state_d = ST_IDLE;
      trig_d  = 1'b0;
      sh0_d   = '0;
      sh1_d   = '0;
      cnt_d   = '0;
      bit_d   = '0;
      ovr_d   = '0;
      out0_d  = IDLE_LEVEL;
      out1_d  = IDLE_LEVEL;
      done_d  = 1'b0;
      busy_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      trig_q  <= 1'b0;
      sh0_q   <= '0;
      sh1_q   <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      out0_q  <= IDLE_LEVEL;
      out1_q  <= IDLE_LEVEL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      trig_q  <= trig_d;
      sh0_q   <= sh0_d;
      sh1_q   <= sh1_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      out0_q  <= out0_d;
      out1_q  <= out1_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  assign dut_o_dnn_output_0 = out0_q;
  assign dut_o_dnn_output_1 = out1_q;
  assign status_busy        = busy_q;
  assign status_done        = done_q;
  assign status_overrun_cnt = ovr_q;
  assign responder_state    = state_q;

endmodule

// File: tb/tb_ip2_dnn_responder.sv
// tb/tb_ip2_dnn_responder.sv - directed self-checking bench for ip2_dnn_responder
module tb_ip2_dnn_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        reset_not;
  logic        trig;
  logic [47:0] pat0;
  logic [47:0] pat1;
  logic [5:0]  lat;
  logic        out0;
  logic        out1;
  logic        busy;
  logic        done;
  logic [7:0]  ovr;
  logic [2:0]  st;

  int errors = 0;
  int checks = 0;

  logic       cap0 [0:127];
  logic       cap1 [0:127];
  logic       capd [0:127];
  logic       capb [0:127];
  logic [2:0] caps [0:127];

  ip2_dnn_responder dut (
    .clk                     (clk),
    .reset                   (reset),
    .enable                  (enable),
    .dut_i_reset_not         (reset_not),
    .dut_i_vin_test_trig_out (trig),
    .cfg_pattern_0           (pat0),
    .cfg_pattern_1           (pat1),
    .cfg_latency             (lat),
    .dut_o_dnn_output_0      (out0),
    .dut_o_dnn_output_1      (out1),
    .status_busy             (busy),
    .status_done             (done),
    .status_overrun_cnt      (ovr),
    .responder_state         (st)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Record n cycles after a trigger edge; optionally re-pulse trig or drop reset_not on a given cycle
  task automatic capture(input int n, input int retrig_at, input int abort_at);
    for (int k = 1; k <= n; k++) begin
      step();
      cap0[k] = out0;
      cap1[k] = out1;
      capd[k] = done;
      capb[k] = busy;
      caps[k] = st;
      if (k == retrig_at) trig = 1'b1;
      if (k == retrig_at + 1) trig = 1'b0;
      if (k == abort_at) reset_not = 1'b0;
    end
  endtask

  task automatic fire();
    trig = 1'b1;
    step();
    trig = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; reset_not = 1'b1; trig = 1'b0;
    pat0 = '0; pat1 = '0; lat = '0;
    step(); step();
    checks++; if (st !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", st); end
    checks++; if ({out0, out1, busy, done} !== 4'b0) begin errors++; $display("FAIL reset_outs got=%b exp=0000", {out0, out1, busy, done}); end
    checks++; if (ovr !== 8'd0) begin errors++; $display("FAIL reset_ovr got=%0d exp=0", ovr); end
    reset = 1'b0;
    step(); step();
    checks++; if (st !== 3'd2) begin errors++; $display("FAIL release_armed got=%0d exp=2", st); end
  endtask

  task automatic test_latency3();
    logic [47:0] p0, p1;
    logic e0, e1;
    p0 = 48'hA5A5_0000_FFFF; p1 = 48'h0000_0000_0001;
    pat0 = p0; pat1 = p1; lat = 6'd3;
    fire();
    pat0 = 48'h1234_5678_9ABC; pat1 = 48'hFFFF_FFFF_FFFF; lat = 6'd9;
    capture(55, -1, -1);
    for (int k = 1; k <= 55; k++) begin
      e0 = (k >= 4 && k <= 51) ? p0[51-k] : 1'b0;
      e1 = (k >= 4 && k <= 51) ? p1[51-k] : 1'b0;
      checks++; if (cap0[k] !== e0) begin errors++; $display("FAIL l3_out0 cyc=%0d got=%b exp=%b", k, cap0[k], e0); end
      checks++; if (cap1[k] !== e1) begin errors++; $display("FAIL l3_out1 cyc=%0d got=%b exp=%b", k, cap1[k], e1); end
      checks++; if (capd[k] !== (k == 52)) begin errors++; $display("FAIL l3_done cyc=%0d got=%b exp=%b", k, capd[k], (k == 52)); end
    end
    checks++; if (capb[1] !== 1'b1) begin errors++; $display("FAIL l3_busy_start got=%b exp=1", capb[1]); end
    checks++; if (capb[53] !== 1'b0) begin errors++; $display("FAIL l3_busy_end got=%b exp=0", capb[53]); end
    checks++; if (caps[55] !== 3'd2) begin errors++; $display("FAIL l3_rearm got=%0d exp=2", caps[55]); end
  endtask

  task automatic test_latency0();
    logic e0;
    int bad;
    pat0 = 48'h8000_0000_0001; pat1 = '0; lat = 6'd0;
    fire();
    capture(51, -1, -1);
    bad = 0;
    for (int k = 1; k <= 51; k++) begin
      e0 = (k == 1 || k == 48);
      if (cap0[k] !== e0 || cap1[k] !== 1'b0 || capd[k] !== (k == 49)) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL l0_stream bad_cycles=%0d exp=0", bad); end
    checks++; if (cap0[1] !== 1'b1) begin errors++; $display("FAIL l0_first_bit got=%b exp=1", cap0[1]); end
    checks++; if (capd[49] !== 1'b1) begin errors++; $display("FAIL l0_done got=%b exp=1", capd[49]); end
  endtask

  task automatic test_overrun();
    logic [47:0] p0, p1;
    int bad;
    p0 = 48'hF0F0_1234_5678; p1 = 48'h0F0F_ABCD_EF01;
    pat0 = p0; pat1 = p1; lat = 6'd0;
    fire();
    capture(50, 10, -1);
    bad = 0;
    for (int k = 1; k <= 48; k++)
      if (cap0[k] !== p0[48-k] || cap1[k] !== p1[48-k]) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL ovr_stream bad_cycles=%0d exp=0", bad); end
    checks++; if (capd[49] !== 1'b1) begin errors++; $display("FAIL ovr_done got=%b exp=1", capd[49]); end
    checks++; if (ovr !== 8'd1) begin errors++; $display("FAIL ovr_one got=%0d exp=1", ovr); end
    lat = 6'd63;
    for (int k = 0; k < 700; k++) begin
      trig = ~trig;
      step();
    end
    trig = 1'b0;
    for (int k = 0; k < 130; k++) step();
    checks++; if (ovr !== 8'd255) begin errors++; $display("FAIL ovr_saturate got=%0d exp=255", ovr); end
    checks++; if (st !== 3'd2) begin errors++; $display("FAIL ovr_idle_after got=%0d exp=2", st); end
  endtask

  task automatic test_abort();
    logic [47:0] p0, p1;
    int bad, dones;
    p0 = 48'hDEAD_BEEF_CAFE;
    pat0 = p0; pat1 = '0; lat = 6'd0;
    fire();
    capture(60, -1, 20);
    bad = 0; dones = 0;
    for (int k = 1; k <= 60; k++) begin
      if (capd[k]) dones++;
      if (k <= 20 && cap0[k] !== p0[48-k]) bad++;
      if (k >= 21 && (cap0[k] !== 1'b0 || capb[k] !== 1'b0)) bad++;
    end
    checks++; if (caps[21] !== 3'd1) begin errors++; $display("FAIL abort_state got=%0d exp=1", caps[21]); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL abort_outputs bad_cycles=%0d exp=0", bad); end
    checks++; if (dones !== 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", dones); end
    reset_not = 1'b1;
    step(); step();
    p0 = 48'h1357_9BDF_2468; p1 = ~p0;
    pat0 = p0; pat1 = p1; lat = 6'd2;
    fire();
    capture(52, -1, -1);
    bad = 0;
    for (int k = 1; k <= 52; k++) begin
      if (k >= 3 && k <= 50 && (cap0[k] !== p0[50-k] || cap1[k] !== p1[50-k])) bad++;
      if ((k < 3 || k > 50) && (cap0[k] !== 1'b0 || cap1[k] !== 1'b0)) bad++;
      if (capd[k] !== (k == 51)) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL fresh_stream bad_cycles=%0d exp=0", bad); end
  endtask

  task automatic test_reset_priority_and_hold();
    int dones;
    pat0 = 48'hFFFF_FFFF_FFFF; pat1 = 48'hFFFF_FFFF_FFFF; lat = 6'd0;
    reset_not = 1'b0; trig = 1'b1;
    step();
    checks++; if (st !== 3'd1) begin errors++; $display("FAIL prio_state got=%0d exp=1", st); end
    reset_not = 1'b1;
    dones = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (out0 !== 1'b0 || busy !== 1'b0) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL prio_no_capture bad_cycles=%0d exp=0", dones); end
    trig = 1'b0;
    step();
    trig = 1'b1;
    dones = 0;
    for (int k = 0; k < 110; k++) begin
      step();
      if (done) dones++;
    end
    checks++; if (dones !== 1) begin errors++; $display("FAIL held_trig_done_count got=%0d exp=1", dones); end
    trig = 1'b0;
    step();
  endtask

  task automatic test_async_and_enable();
    pat0 = 48'hFFFF_FFFF_FFFF; pat1 = 48'hFFFF_FFFF_FFFF; lat = 6'd20;
    fire();
    step(); step(); step(); step();
    checks++; if (st !== 3'd3 || busy !== 1'b1) begin errors++; $display("FAIL async_pre st=%0d busy=%b exp st=3 busy=1", st, busy); end
    #2 reset = 1'b1;
    #1;
    checks++; if (st !== 3'd0 || busy !== 1'b0 || ovr !== 8'd0) begin errors++; $display("FAIL async_reset st=%0d busy=%b ovr=%0d exp 0/0/0", st, busy, ovr); end
    step();
    reset = 1'b0;
    step(); step();
    checks++; if (st !== 3'd2) begin errors++; $display("FAIL async_rearm got=%0d exp=2", st); end
    lat = 6'd0;
    fire();
    step(); step(); step(); step();
    checks++; if (st !== 3'd4 || out0 !== 1'b1) begin errors++; $display("FAIL en_pre st=%0d out0=%b exp st=4 out0=1", st, out0); end
    enable = 1'b0;
    step();
    checks++; if (st !== 3'd0 || out0 !== 1'b0 || out1 !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL en_idle st=%0d outs=%b%b busy=%b exp 0/00/0", st, out0, out1, busy); end
    enable = 1'b1;
    step(); step();
    checks++; if (st !== 3'd2) begin errors++; $display("FAIL en_rearm got=%0d exp=2", st); end
  endtask

  initial begin
    test_reset();
    test_latency3();
    test_latency0();
    test_overrun();
    test_abort();
    test_reset_priority_and_hold();
    test_async_and_enable();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
